// File: rtl/vga_color_stage_if.sv
// rtl/vga_color_stage_if.sv - video, palette-write and DAC signals of vga_color_stage
interface vga_color_stage_if #(
  parameter int IN_BITS = 1,
  parameter int R_W     = 5,
  parameter int G_W     = 6,
  parameter int B_W     = 5
);
  logic                     pix_ce;
  logic [IN_BITS-1:0]       video_in;
  logic                     hs_in;
  logic                     vs_in;
  logic                     pal_we;
  logic [IN_BITS-1:0]       pal_addr;
  logic [R_W+G_W+B_W-1:0]   pal_data;
  logic                     scanline_en;
  logic                     invert_en;
  logic                     blink_en;
  logic [R_W-1:0]           vga_r;
  logic [G_W-1:0]           vga_g;
  logic [B_W-1:0]           vga_b;
  logic                     vga_hs;
  logic                     vga_vs;
  logic [7:0]               frame_cnt;

  modport master (
    output pix_ce, video_in, hs_in, vs_in, pal_we, pal_addr, pal_data,
    output scanline_en, invert_en, blink_en,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_cnt
  );

  modport slave (
    input  pix_ce, video_in, hs_in, vs_in, pal_we, pal_addr, pal_data,
    input  scanline_en, invert_en, blink_en,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_cnt
  );
endinterface

// File: rtl/vga_color_stage.sv
// rtl/vga_color_stage.sv - palette-mapped VGA colour stage with sync-derived blanking
module vga_color_stage #(
  parameter int IN_BITS      = 1,
  parameter int R_W          = 5,
  parameter int G_W          = 6,
  parameter int B_W          = 5,
  parameter int H_START      = 48,
  parameter int H_ACTIVE     = 640,
  parameter int V_START      = 33,
  parameter int V_ACTIVE     = 480,
  parameter bit SYNC_ACT_LOW = 1'b1
) (
  input logic              clk,
  input logic              reset,
  vga_color_stage_if.slave bus
);
  localparam int          PW      = R_W + G_W + B_W;
  localparam int          NPAL    = 1 << IN_BITS;
  localparam logic        SYNC_ON = ~SYNC_ACT_LOW;
  localparam logic [12:0] H_LO    = 13'(H_START);
  localparam logic [12:0] H_HI    = 13'(H_START + H_ACTIVE);
  localparam logic [11:0] V_LO    = 12'(V_START);
  localparam logic [11:0] V_HI    = 12'(V_START + V_ACTIVE);

  logic               hs_act, vs_act, hs_lead, vs_lead, active;
  logic [11:0]        hcnt_q, hcnt_d;
  logic [10:0]        vcnt_q, vcnt_d;
  logic [7:0]         frame_q, frame_d;
  logic               hs_prev_q, vs_prev_q;
  logic               vs_seen_q, vs_seen_d;

  logic [IN_BITS-1:0] s1_idx_q, s1_idx_d;
  logic               s1_act_q, s1_dark_q, s1_hs_q, s1_vs_q;

  logic [PW-1:0]      pal_q [NPAL];
  logic [PW-1:0]      pal_rd;
  logic [R_W-1:0]     r_q, r_d;
  logic [G_W-1:0]     g_q, g_d;
  logic [B_W-1:0]     b_q, b_d;
  logic               hs_o_q, vs_o_q;

  assign hs_act  = (bus.hs_in == SYNC_ON);
  assign vs_act  = (bus.vs_in == SYNC_ON);
  assign hs_lead = hs_act && !hs_prev_q;
  assign vs_lead = vs_act && !vs_prev_q;

  // Blank until a vsync edge has been seen so a reset mid-frame cannot count into the window.
  assign active = vs_seen_q
               && ({1'b0, hcnt_q} >= H_LO) && ({1'b0, hcnt_q} < H_HI)
               && ({1'b0, vcnt_q} >= V_LO) && ({1'b0, vcnt_q} < V_HI);

  always_comb begin
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    frame_d   = frame_q;
    vs_seen_d = vs_seen_q | vs_lead;
    if (hs_act) begin
      hcnt_d = '0;
    end else if (hcnt_q != '1) begin
      hcnt_d = hcnt_q + 12'd1;
    end
    if (vs_act) begin
      vcnt_d = '0;
    end else if (hs_lead && vcnt_q != '1) begin
      vcnt_d = vcnt_q + 11'd1;
    end
    if (vs_lead) begin
      frame_d = frame_q + 8'd1;
    end
  end

  always_comb begin
    s1_idx_d = bus.video_in ^ {IN_BITS{bus.invert_en}};
    if (bus.blink_en && frame_q[5]) begin
      s1_idx_d = '0;
    end
  end

  // Palette read sees the pre-write contents when a write hits the same entry this edge.
  always_comb begin
    pal_rd = pal_q[s1_idx_q];
    r_d    = pal_rd[PW-1 -: R_W];
    g_d    = pal_rd[G_W+B_W-1 -: G_W];
    b_d    = pal_rd[B_W-1:0];
    if (s1_dark_q) begin
      r_d = r_d >> 1;
      g_d = g_d >> 1;
      b_d = b_d >> 1;
    end
    if (!s1_act_q) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      frame_q   <= '0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      vs_seen_q <= 1'b0;
      s1_idx_q  <= '0;
      s1_act_q  <= 1'b0;
      s1_dark_q <= 1'b0;
      s1_hs_q   <= 1'b0;
      s1_vs_q   <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_o_q    <= ~SYNC_ON;
      vs_o_q    <= ~SYNC_ON;
    end else if (bus.pix_ce) begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      frame_q   <= frame_d;
      hs_prev_q <= hs_act;
      vs_prev_q <= vs_act;
      vs_seen_q <= vs_seen_d;
      s1_idx_q  <= s1_idx_d;
      s1_act_q  <= active;
      s1_dark_q <= bus.scanline_en && vcnt_q[0];
      s1_hs_q   <= hs_act;
      s1_vs_q   <= vs_act;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_o_q    <= s1_hs_q ? SYNC_ON : ~SYNC_ON;
      vs_o_q    <= s1_vs_q ? SYNC_ON : ~SYNC_ON;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NPAL; i++) begin
        pal_q[i] <= (i == 0) ? '0 : '1;
      end
    end else if (bus.pal_we) begin
      pal_q[bus.pal_addr] <= bus.pal_data;
    end
  end

  assign bus.vga_r     = r_q;
  assign bus.vga_g     = g_q;
  assign bus.vga_b     = b_q;
  assign bus.vga_hs    = hs_o_q;
  assign bus.vga_vs    = vs_o_q;
  assign bus.frame_cnt = frame_q;
endmodule

// File: tb/tb_vga_color_stage.sv
// tb/tb_vga_color_stage.sv - self-checking bench for vga_color_stage on a reduced 28x12 raster
module tb_vga_color_stage;
  localparam int HS = 4, HA = 16, VS = 2, VA = 6;
  localparam int HT = 28, VT = 12, HSYNC = 4, VSYNC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_color_stage_if #(.IN_BITS(2), .R_W(5), .G_W(6), .B_W(5)) bus();

  vga_color_stage #(
    .IN_BITS(2), .R_W(5), .G_W(6), .B_W(5),
    .H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA), .SYNC_ACT_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int total = 0;
  int bad = 0;
  int bx = 0, by = 0;
  int tally = 0;
  logic last_vs = 1'b1;

  typedef struct packed {
    logic [1:0] idx;
    logic       act;
    logic       dark;
    logic       hs;
    logic       vs;
  } px_t;

  px_t         q[$];
  int          m_h, m_v, m_frame;
  bit          m_hsp, m_vsp, m_seen;
  logic [15:0] m_pal [4];
  logic [4:0]  e_r, e_b;
  logic [5:0]  e_g;
  logic        e_hs, e_vs;
  logic [7:0]  e_fc;

  typedef struct {
    logic [1:0] video;
    bit         inv;
    bit         scan;
    int         y;
    int         x;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_rgb(input string name, input int r, input int g, input int b);
    check(name, {bus.vga_r, bus.vga_g, bus.vga_b}, {5'(r), 6'(g), 5'(b)});
  endtask

  // Reference: a queue of pixels; each pix_ce pushes the new pixel and displays the one before it.
  task automatic model_step();
    bit   hs_a, vs_a;
    px_t  p, o;
    logic [15:0] e;
    int   r, g, b;
    hs_a = (bus.hs_in == 1'b0);
    vs_a = (bus.vs_in == 1'b0);
    if (reset) begin
      m_h = 0; m_v = 0; m_frame = 0;
      m_hsp = 0; m_vsp = 0; m_seen = 0;
      m_pal[0] = 16'h0000;
      for (int i = 1; i < 4; i++) m_pal[i] = 16'hFFFF;
      q.delete();
      q.push_back('0);
      e_r = 0; e_g = 0; e_b = 0; e_hs = 1'b1; e_vs = 1'b1; e_fc = 0;
      return;
    end
    if (bus.pix_ce) begin
      p.idx  = (bus.blink_en && ((m_frame / 32) % 2 == 1)) ? 2'd0 : (bus.video_in ^ {2{bus.invert_en}});
      p.act  = m_seen && m_h >= HS && m_h < HS + HA && m_v >= VS && m_v < VS + VA;
      p.dark = bus.scanline_en && (m_v % 2 == 1);
      p.hs   = hs_a;
      p.vs   = vs_a;
      q.push_back(p);
      o = q.pop_front();
      e = m_pal[o.idx];
      r = e[15:11]; g = e[10:5]; b = e[4:0];
      if (o.dark) begin r = r / 2; g = g / 2; b = b / 2; end
      if (!o.act) begin r = 0; g = 0; b = 0; end
      e_r = 5'(r); e_g = 6'(g); e_b = 5'(b);
      e_hs = !o.hs; e_vs = !o.vs;
      if (vs_a && !m_vsp) begin m_frame = (m_frame + 1) % 256; m_seen = 1; end
      if (vs_a) m_v = 0;
      else if (hs_a && !m_hsp && m_v < 2047) m_v = m_v + 1;
      if (hs_a) m_h = 0;
      else if (m_h < 4095) m_h = m_h + 1;
      m_hsp = hs_a;
      m_vsp = vs_a;
    end
    if (bus.pal_we) m_pal[bus.pal_addr] = bus.pal_data;
    e_fc = 8'(m_frame);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("model", {bus.vga_r, bus.vga_g, bus.vga_b, bus.vga_hs, bus.vga_vs, bus.frame_cnt},
          {e_r, e_g, e_b, e_hs, e_vs, e_fc});
  endtask

  task automatic drive(input logic [1:0] v, input logic h, input logic vv, input logic ce);
    bus.video_in = v;
    bus.hs_in    = h;
    bus.vs_in    = vv;
    bus.pix_ce   = ce;
    if (reset) begin
      tally = 0;
      last_vs = 1'b1;
    end else if (ce) begin
      if (vv == 1'b0 && last_vs == 1'b1) tally = (tally + 1) % 256;
      last_vs = vv;
    end
    tick();
  endtask

  task automatic pix(input logic [1:0] v);
    drive(v, (bx < HSYNC) ? 1'b0 : 1'b1, (by < VSYNC) ? 1'b0 : 1'b1, 1'b1);
    bx++;
    if (bx == HT) begin
      bx = 0;
      by = (by + 1) % VT;
    end
  endtask

  task automatic idle(input logic [1:0] v);
    drive(v, (bx < HSYNC) ? 1'b0 : 1'b1, (by < VSYNC) ? 1'b0 : 1'b1, 1'b0);
  endtask

  task automatic run_to(input int y, input int x, input logic [1:0] v);
    for (int n = 0; n < HT * VT && !(bx == x && by == y); n++) pix(v);
  endtask

  task automatic pal_write(input logic [1:0] a, input logic [15:0] d);
    bus.pal_we = 1'b1; bus.pal_addr = a; bus.pal_data = d;
    idle(2'd0);
    bus.pal_we = 1'b0;
  endtask

  initial begin
    int nz;
    vecs[0]  = '{2'd1, 0, 0, 3, 12, 5'd31, 6'd63, 5'd31};
    vecs[1]  = '{2'd0, 0, 0, 3, 12, 5'd0,  6'd0,  5'd0};
    vecs[2]  = '{2'd3, 1, 0, 3, 12, 5'd0,  6'd0,  5'd0};
    vecs[3]  = '{2'd0, 1, 0, 3, 12, 5'd31, 6'd63, 5'd31};
    vecs[4]  = '{2'd1, 0, 1, 4, 12, 5'd15, 6'd31, 5'd15};
    vecs[5]  = '{2'd1, 0, 1, 3, 12, 5'd31, 6'd63, 5'd31};
    vecs[6]  = '{2'd1, 0, 0, 3, 5,  5'd0,  6'd0,  5'd0};
    vecs[7]  = '{2'd1, 0, 0, 10, 12, 5'd0, 6'd0,  5'd0};
    vecs[8]  = '{2'd1, 0, 0, 3, 8,  5'd31, 6'd63, 5'd31};
    vecs[9]  = '{2'd1, 0, 0, 3, 7,  5'd0,  6'd0,  5'd0};
    vecs[10] = '{2'd1, 0, 0, 8, 23, 5'd31, 6'd63, 5'd31};
    vecs[11] = '{2'd1, 0, 0, 9, 12, 5'd0,  6'd0,  5'd0};

    bus.pix_ce = 0; bus.video_in = 0; bus.hs_in = 1; bus.vs_in = 1;
    bus.pal_we = 0; bus.pal_addr = 0; bus.pal_data = 0;
    bus.scanline_en = 0; bus.invert_en = 0; bus.blink_en = 0;

    reset = 1'b1;
    drive(2'd1, 1'b1, 1'b1, 1'b1);
    check("reset_state", {bus.vga_r, bus.vga_g, bus.vga_b, bus.vga_hs, bus.vga_vs, bus.frame_cnt},
          {16'd0, 1'b1, 1'b1, 8'd0});
    for (int i = 0; i < 3; i++) drive(2'd1, 1'b1, 1'b1, 1'b1);
    reset = 1'b0;

    for (int n = 0; n < HT * VT; n++) pix(2'd0);

    foreach (vecs[i]) begin
      bus.invert_en   = vecs[i].inv;
      bus.scanline_en = vecs[i].scan;
      run_to(vecs[i].y, vecs[i].x, vecs[i].video);
      pix(vecs[i].video);
      pix(vecs[i].video);
      check_rgb($sformatf("vec%0d", i), vecs[i].r, vecs[i].g, vecs[i].b);
    end
    bus.invert_en = 0; bus.scanline_en = 0;

    run_to(5, 10, 2'd1);
    bus.pal_we = 1'b1; bus.pal_addr = 2'd1; bus.pal_data = 16'hF800;
    pix(2'd1);
    bus.pal_we = 1'b0;
    check_rgb("pal_old_on_write", 31, 63, 31);
    pix(2'd1);
    check_rgb("pal_new_red", 31, 0, 0);
    pal_write(2'd1, 16'hFFFF);

    bus.blink_en = 1'b1;
    for (int f = 0; f < 80 && tally < 70; f++) begin
      run_to(5, 12, 2'd1);
      pix(2'd1);
      pix(2'd1);
      check("blink_fc", bus.frame_cnt, 8'(tally));
      if (tally >= 32 && tally <= 63) check_rgb($sformatf("blink_f%0d", tally), 0, 0, 0);
      else check_rgb($sformatf("blink_f%0d", tally), 31, 63, 31);
    end
    bus.blink_en = 1'b0;

    for (int n = 0; n < 600 && tally != 255; n++) begin
      drive(2'd0, 1'b1, 1'b1, 1'b1);
      drive(2'd0, 1'b1, 1'b0, 1'b1);
    end
    check("fc_255", bus.frame_cnt, 8'd255);
    drive(2'd0, 1'b1, 1'b1, 1'b1);
    drive(2'd0, 1'b1, 1'b0, 1'b1);
    check("fc_wrap", bus.frame_cnt, 8'd0);
    bx = 0; by = 0;

    run_to(5, 27, 2'd1);
    pix(2'd1);
    pix(2'd1);
    check("hs_lat0", bus.vga_hs, 1'b1);
    idle(2'd0);
    check("hs_lat1", bus.vga_hs, 1'b1);
    pix(2'd1);
    check("hs_lat2", bus.vga_hs, 1'b0);
    for (int n = 0; n < HT && bx != 8; n++) begin
      idle(2'(n));
      pix(2'd1);
    end
    idle(2'd2);
    pix(2'd1);
    check_rgb("col_lat0", 0, 0, 0);
    idle(2'd0);
    check_rgb("col_lat1", 0, 0, 0);
    pix(2'd1);
    check_rgb("col_lat2", 31, 63, 31);
    for (int n = 0; n < 2 * HT; n++) begin
      idle(2'(n));
      pix(2'd1);
    end

    for (int n = 0; n < 5 * HT * VT; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        bus.scanline_en = 1'($urandom);
        bus.invert_en   = 1'($urandom);
        bus.blink_en    = 1'($urandom);
      end
      if ($urandom_range(0, 39) == 0) begin
        bus.pal_we = 1'b1; bus.pal_addr = 2'($urandom); bus.pal_data = 16'($urandom);
      end
      if ($urandom_range(0, 3) != 0) pix(2'($urandom));
      else idle(2'($urandom));
      bus.pal_we = 1'b0;
    end
    bus.scanline_en = 0; bus.invert_en = 0; bus.blink_en = 0;

    pal_write(2'd1, 16'hF800);
    run_to(5, 12, 2'd1);
    reset = 1'b1;
    pix(2'd1);
    reset = 1'b0;
    check("midline_reset", {bus.vga_r, bus.vga_g, bus.vga_b, bus.vga_hs, bus.vga_vs, bus.frame_cnt},
          {16'd0, 1'b1, 1'b1, 8'd0});
    nz = 0;
    for (int n = 0; n < HT * VT && !(bx == 0 && by == 0); n++) begin
      pix(2'd1);
      if ({bus.vga_r, bus.vga_g, bus.vga_b} != 16'd0) nz++;
    end
    check("no_active_before_vs", 64'(nz), 64'd0);
    run_to(5, 12, 2'd1);
    pix(2'd1);
    pix(2'd1);
    check_rgb("pal1_reset_white", 31, 63, 31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_color_stage.md
# vga_color_stage

Parametrised video output stage between a retro machine core and the board VGA DAC. It takes an N-bit pixel index plus native sync from the core, regenerates active-area blanking from the syncs, and maps each index through a writable RGB palette. It adds optional scanline darkening, inversion and blink, and delays sync to stay pixel-aligned with colour. It replaces hard-wired replication of a 1-bit video signal onto every DAC bit; defaults reproduce that black/white output exactly.

## Interface
Parameters:
- IN_BITS, 1: pixel index width; palette has 2^IN_BITS entries (1..4).
- R_W, 5: red output width.
- G_W, 6: green output width.
- B_W, 5: blue output width.
- H_START, 48: pixel-enable count after the hsync trailing edge to the first active pixel.
- H_ACTIVE, 640: active pixels per line.
- V_START, 33: line count after the vsync trailing edge to the first active line.
- V_ACTIVE, 480: active lines per frame.
- SYNC_ACT_LOW, 1: sync polarity of both inputs and outputs; 1 = active-low.

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high.
- pix_ce  in  1  pixel clock enable; all video-path state advances only when high.
- video_in  in  IN_BITS  pixel index from the core.
- hs_in  in  1  core horizontal sync.
- vs_in  in  1  core vertical sync.
- pal_we  in  1  palette write strobe.
- pal_addr  in  IN_BITS  palette entry to write.
- pal_data  in  R_W+G_W+B_W  entry value {R,G,B}.
- scanline_en  in  1  darken odd lines.
- invert_en  in  1  invert the pixel index.
- blink_en  in  1  blink enable.
- vga_r  out  R_W  red.
- vga_g  out  G_W  green.
- vga_b  out  B_W  blue.
- vga_hs  out  1  delayed hsync.
- vga_vs  out  1  delayed vsync.
- frame_cnt  out  8  frame counter.

## Operation
- Sync is asserted when the input equals ~SYNC_ACT_LOW.
- hcnt (12 b):
  - On a pix_ce cycle with hs asserted, hcnt <= 0.
  - On other pix_ce cycles, hcnt increments and saturates at 4095.
- vcnt (11 b):
  - While vs is asserted, vcnt <= 0.
  - Otherwise it increments on each hs leading edge (hs asserted on this pix_ce, deasserted on the previous one) and saturates at 2047.
- frame_cnt increments (wraps 255 -> 0) on the vs leading edge.
- active = (H_START <= hcnt < H_START+H_ACTIVE) && (V_START <= vcnt < V_START+V_ACTIVE).
- Stage 1, on pix_ce, registers:
  - idx = video_in ^ {IN_BITS{invert_en}}.
  - If blink_en && frame_cnt[5], idx = 0.
  - Also registers active, odd = vcnt[0], hs_in and vs_in.
- Stage 2, on pix_ce:
  - rgb = palette[idx].
  - If scanline_en && odd, each component is logically shifted right by 1.
  - If !active, rgb = 0.
  - vga_hs and vga_vs take the stage-1 syncs.
- Palette:
  - Register file; writes are independent of pix_ce.
  - When pal_we is high, palette[pal_addr] <= pal_data at that clk edge.
  - A stage-2 read of the same entry in the same cycle returns the old value.
- Reset:
  - Palette entry 0 = all zeros; all other entries = all ones.
  - hcnt, vcnt, frame_cnt and all pipeline registers = 0.
  - vga_r, vga_g and vga_b = 0.
  - vga_hs and vga_vs = inactive level (SYNC_ACT_LOW).
- Reset mid-frame: the next clk shows the reset values above. The first active pixel appears only after a full vsync has been seen.

## Timing
- Latency is exactly 2 pix_ce cycles from video_in/hs_in/vs_in to vga_* for colour and sync alike; they stay aligned.
- Outputs hold between pix_ce pulses.
- pix_ce held high gives 1 pixel per clk.
- pix_ce low freezes all counters and pipeline stages; palette writes still complete.
- Simultaneous hs leading edge and vs asserted: vs wins, vcnt = 0.
- Saturated counters stay inactive; a missing sync therefore blanks output rather than wrapping into the active area.
- A change to scanline_en, invert_en or blink_en takes effect on pixels entering stage 1 at the next pix_ce.

## Test plan
- Defaults, pix_ce=1, 800x525 timing:
  - video_in=1 in the active window -> vga_r=31, vga_g=63, vga_b=31 two clks later.
  - video_in=1 outside the window -> rgb=0.
- Write palette[1]=16'hF800 while video_in=1 -> output red 31, green 0, blue 0 from the write clk+1. A pixel reading entry 1 in the write cycle shows the old white.
- scanline_en=1, full-white frame -> even lines give 31/63/31, odd lines give 15/31/15. invert_en=1 turns the active area black (0/0/0).
- blink_en=1 over 64 frames -> frame_cnt 32..63 blank to index 0. frame_cnt wraps 255 -> 0.
- pix_ce every 2nd clk -> latency 2 pix_ce (4 clks); hs/vs edges are delayed identically to colour.
- Reset asserted mid-line -> next clk rgb=0, hs=vs=1, frame_cnt=0, palette[1]=all ones; no active pixels before the first vsync after release.
